// File: rtl/trans_out_framer.sv
// trans_out_framer: FWFT FIFO output stage that tags a transposed stream with AXI-Stream framing.
// Ports:
//   clk, rst (async, active-low)
//   s_axis_tdata/tvalid/tready : untagged transposed input stream
//   m_axis_tdata/tvalid/tready/tlast/tuser : framed output stream
//   frame_done : one-cycle pulse after the last beat of a frame is delivered
//   frame_cnt  : completed frame count, wraps at 16 bits
module trans_out_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW        = 64,
  parameter int CLO        = 2400,
  parameter int FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = ROW > 1 ? $clog2(ROW) : 1;
  localparam int LW    = CLO > 1 ? $clog2(CLO) : 1;
  localparam int W     = DATA_WIDTH + 3;
  logic [W-1:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   occ, occ_next;
  logic [BW-1:0]      beat;
  logic [LW-1:0]      line;
  logic               push, pop, last_beat, last_line, fin;
  logic [W-1:0]       head;
  assign push      = s_axis_tvalid & s_axis_tready;
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign last_beat = beat == BW'(ROW - 1);
  assign last_line = line == LW'(CLO - 1);
  assign occ_next  = occ + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
  assign head      = mem[rd_ptr];
  // entry layout {eof, tuser, tlast, data}; eof marks the final line of a frame
  assign fin       = pop & head[W-1] & head[DATA_WIDTH];
  assign m_axis_tvalid = occ != '0;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? head[W-2:0] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {last_line, beat == '0 && line == '0, last_beat, s_axis_tdata};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      beat          <= '0;
      line          <= '0;
      s_axis_tready <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
        beat   <= last_beat ? '0 : beat + BW'(1);
        if (last_beat) line <= last_line ? '0 : line + LW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      occ           <= occ_next;
      // registered ready: no write-through while full, rises the cycle after a pop
      s_axis_tready <= occ_next < (FIFO_AW+1)'(DEPTH);
      frame_done    <= fin;
      frame_cnt     <= frame_cnt + 16'(fin);
    end
endmodule

// File: tb/tb_trans_out_framer.sv
// tb_trans_out_framer: directed and randomized checks of trans_out_framer against a queue model.
module tb_trans_out_framer;
  localparam int R = 4, C = 3, AW = 2, D = 4, F = R * C;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic [31:0] s_tdata, m_tdata;
  logic s_tvalid, s_tready, m_tvalid, m_tready, m_tlast, m_tuser, fdone;
  logic [15:0] fcnt;
  logic [31:0] b_sdata, b_mdata;
  logic b_svalid, b_sready, b_mvalid, b_mready, b_tlast, b_tuser, b_fdone;
  logic [15:0] b_fcnt;
  trans_out_framer #(.DATA_WIDTH(32), .ROW(R), .CLO(C), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .frame_done(fdone), .frame_cnt(fcnt));
  trans_out_framer #(.DATA_WIDTH(32), .ROW(1), .CLO(1), .FIFO_AW(2)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_sdata), .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
    .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
    .frame_done(b_fdone), .frame_cnt(b_fcnt));
  typedef struct {logic [31:0] d; int idx;} ent_t;
  ent_t q[$];
  int errors = 0, checks = 0, acc = 0;
  logic [15:0] efcnt;
  logic erdy;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic reset_model();
    q.delete();
    acc = 0;
    efcnt = 0;
    erdy = 0;
  endtask
  // one clock cycle: drive at negedge, check head/ready, step model, check post-edge status
  task automatic cyc(input logic v, input logic r, input logic [31:0] d);
    logic ih, oh, efd;
    ent_t e;
    s_tvalid = v; s_tdata = d; m_tready = r;
    #1;
    chk("s_tready", s_tready, erdy);
    chk("m_tvalid", m_tvalid, q.size() != 0);
    if (q.size() != 0) begin
      chk("tdata", m_tdata, q[0].d);
      chk("tlast", m_tlast, q[0].idx % R == R - 1);
      chk("tuser", m_tuser, q[0].idx % F == 0);
    end else chk("idle_zero", {m_tdata, m_tlast, m_tuser}, 0);
    ih = v & s_tready;
    oh = r & m_tvalid;
    efd = 0;
    if (oh && q.size() != 0) begin
      e = q.pop_front();
      efd = e.idx % F == F - 1;
    end
    if (ih) begin
      q.push_back('{d, acc});
      acc++;
    end
    erdy = q.size() < D;
    if (efd) efcnt++;
    @(posedge clk);
    #1;
    chk("frame_done", fdone, efd);
    chk("frame_cnt", fcnt, efcnt);
    @(negedge clk);
  endtask
  initial begin
    int a0, n, bacc, bdel, bpulse, bbad, bn;
    logic [15:0] bmax;
    s_tvalid = 0; s_tdata = 0; m_tready = 0;
    b_svalid = 0; b_sdata = 0; b_mready = 0;
    reset_model();
    #2;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_out", {m_tdata, m_tlast, m_tuser}, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_status", {fdone, fcnt}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1;
    cyc(0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(1, 1, i);
    cyc(0, 1, 0); cyc(0, 1, 0);
    chk("t1_frames", fcnt, 1);
    a0 = acc;
    for (int i = 0; i < 8; i++) cyc(1, 0, 100 + i);
    chk("t2_accepted", acc - a0, 4);
    chk("t2_hold", m_tdata, 100);
    chk("t2_full", s_tready, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0);
    cyc(1, 0, 200); cyc(1, 0, 201);
    for (int i = 0; i < 20; i++) cyc(1, 1, 202 + i);
    chk("t5_ready", s_tready, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 300 + i);
    chk("t4_buffered", m_tvalid, 1);
    #2 rst = 0;
    #1;
    chk("t4_async_tvalid", m_tvalid, 0);
    chk("t4_async_out", {m_tdata, m_tlast, m_tuser}, 0);
    chk("t4_async_misc", {s_tready, fdone, fcnt}, 0);
    reset_model();
    @(negedge clk);
    rst = 1;
    cyc(0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(1, 1, 400 + i);
    cyc(0, 1, 0); cyc(0, 1, 0);
    chk("t4_frames", fcnt, 1);
    n = 0;
    while (acc < 12 + 20 * F && n < 5000) begin
      cyc(1'($urandom % 2), 1'($urandom % 2), $urandom);
      n++;
    end
    while (q.size() != 0 && n < 6000) begin
      cyc(0, 1'($urandom % 2), 0);
      n++;
    end
    cyc(0, 1, 0);
    chk("t3_timeout", n < 6000, 1);
    chk("t3_frames", fcnt, 21);
    bacc = 0; bdel = 0; bpulse = 0; bbad = 0; bn = 0; bmax = 0;
    b_mready = 1;
    while (bdel < 65536 && bn < 70000) begin
      b_svalid = bacc < 65536;
      b_sdata = bacc;
      #1;
      if (b_svalid && b_sready) bacc++;
      if (b_mvalid) begin
        if (!(b_tlast && b_tuser && b_mdata == bdel)) bbad++;
        bdel++;
      end
      if (b_fdone) bpulse++;
      if (b_fcnt > bmax) bmax = b_fcnt;
      @(negedge clk);
      bn++;
    end
    b_svalid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (b_fdone) bpulse++;
      @(negedge clk);
    end
    chk("t6_delivered", bdel, 65536);
    chk("t6_bad_beats", bbad, 0);
    chk("t6_pulses", bpulse, 65536);
    chk("t6_max_cnt", bmax, 16'hFFFF);
    chk("t6_wrap", b_fcnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
